// File: rtl/pixel_readout_packer_pkg.sv
// Shared sensor readout types and default geometry for the pixel readout path.
package PixelSensorConfig;

    localparam int PIXEL_BITS         = 8;
    localparam int OUTPUT_BUS_WIDTH   = 4;
    localparam int PIXEL_ARRAY_WIDTH  = 128;
    localparam int PIXEL_ARRAY_HEIGHT = 128;

    typedef logic [PIXEL_BITS-1:0] pixel_t;
    typedef pixel_t [OUTPUT_BUS_WIDTH-1:0] beat_t;

    typedef enum logic {
        FULL = 1'b0,
        BIN2 = 1'b1
    } readout_mode_e;

endpackage

// File: rtl/pixel_readout_packer_if.sv
// Pixel-in / beat-out handshake bundle between the array readout and the sensor bus.
interface pixel_readout_packer_if #(
    parameter int PIXEL_BITS = PixelSensorConfig::PIXEL_BITS,
    parameter int BUS_WIDTH  = PixelSensorConfig::OUTPUT_BUS_WIDTH
);

    logic [PIXEL_BITS-1:0]                in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic                                 out_new_row;
    logic                                 out_frame_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_new_row, out_frame_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_new_row, out_frame_last
    );

endinterface

// File: rtl/pixel_readout_packer_fifo.sv
// First-word-fall-through beat FIFO; head output reads zero while empty.
module readout_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/pixel_readout_packer.sv
// Packs raster-order pixels (full or 2:1 horizontally binned) into BUS_WIDTH-lane
// beats tagged with row-start / frame-end flags, buffered in a small FIFO.
module pixel_readout_packer
    import PixelSensorConfig::*;
#(
    parameter int PIXEL_BITS   = PixelSensorConfig::PIXEL_BITS,
    parameter int BUS_WIDTH    = PixelSensorConfig::OUTPUT_BUS_WIDTH,
    parameter int ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_mode,
    pixel_readout_packer_if.slave  bus,
    output logic                   o_busy,
    output logic                   o_frame_finished
);

    localparam int CW = (ARRAY_WIDTH > 1)  ? $clog2(ARRAY_WIDTH)  : 1;
    localparam int RW = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int LW = (BUS_WIDTH > 1)    ? $clog2(BUS_WIDTH)    : 1;
    localparam int DW = BUS_WIDTH * PIXEL_BITS;
    localparam int FW = DW + 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e                               r_state;
    state_e                               w_state_nxt;
    readout_mode_e                        r_mode;
    logic [CW-1:0]                        r_col;
    logic [RW-1:0]                        r_row;
    logic [LW-1:0]                        r_lane;
    logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] r_lanes;
    logic [PIXEL_BITS-1:0]                r_hold;
    logic                                 r_frame_finished;

    logic                                 w_accept;
    logic                                 w_col_last;
    logic                                 w_row_last;
    logic                                 w_frame_last_pix;
    logic [PIXEL_BITS:0]                  w_sum;
    logic [PIXEL_BITS-1:0]                w_lane_val;
    logic                                 w_lane_fill;
    logic                                 w_beat_done;
    logic                                 w_new_row;
    logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] w_beat;
    logic [FW-1:0]                        w_fifo_wdata;
    logic [FW-1:0]                        w_fifo_rdata;
    logic                                 w_full;
    logic                                 w_empty;
    logic                                 w_pop;
    logic                                 w_last_consumed;

    assign w_accept         = bus.in_valid && bus.in_ready;
    assign w_col_last       = (r_col == CW'(ARRAY_WIDTH - 1));
    assign w_row_last       = (r_row == RW'(ARRAY_HEIGHT - 1));
    assign w_frame_last_pix = w_col_last && w_row_last;

    // Binned lane is the floor average of the held even pixel and the odd one.
    assign w_sum       = {1'b0, r_hold} + {1'b0, bus.in_data};
    assign w_lane_val  = (r_mode == BIN2) ? w_sum[PIXEL_BITS:1] : bus.in_data;
    assign w_lane_fill = w_accept && ((r_mode == FULL) || r_col[0]);
    assign w_beat_done = w_lane_fill && (r_lane == LW'(BUS_WIDTH - 1));
    assign w_new_row   = (r_mode == BIN2) ? (r_col == CW'(2 * BUS_WIDTH - 1))
                                          : (r_col == CW'(BUS_WIDTH - 1));

    always_comb begin
        w_beat                = r_lanes;
        w_beat[BUS_WIDTH-1]   = w_lane_val;
    end

    assign w_fifo_wdata = {w_new_row, w_frame_last_pix, w_beat};

    readout_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_beat_done),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.out_data       = w_fifo_rdata[DW-1:0];
    assign bus.out_frame_last = w_fifo_rdata[FW-2];
    assign bus.out_new_row    = w_fifo_rdata[FW-1];
    assign bus.out_valid      = !w_empty;
    assign bus.in_ready       = (r_state == STREAM) && !w_full;
    assign w_pop              = bus.out_valid && bus.out_ready;
    assign w_last_consumed    = w_pop && bus.out_frame_last;

    assign o_busy           = (r_state != IDLE);
    assign o_frame_finished = r_frame_finished;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_nxt = STREAM;
            STREAM:  if (w_accept && w_frame_last_pix) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_consumed) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode           <= FULL;
            r_col            <= '0;
            r_row            <= '0;
            r_lane           <= '0;
            r_lanes          <= '0;
            r_hold           <= '0;
            r_frame_finished <= 1'b0;
        end else begin
            r_frame_finished <= (r_state == DRAIN) && w_last_consumed;
            if (r_state == IDLE && i_start) begin
                r_mode <= readout_mode_e'(i_mode);
                r_col  <= '0;
                r_row  <= '0;
                r_lane <= '0;
            end else if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (r_mode == BIN2 && !r_col[0]) r_hold <= bus.in_data;
                // The final lane bypasses into the FIFO word, so only earlier lanes are stored.
                if (w_lane_fill) begin
                    if (w_beat_done) begin
                        r_lane <= '0;
                    end else begin
                        r_lanes[r_lane] <= w_lane_val;
                        r_lane          <= r_lane + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout_packer.sv
// Directed bench for pixel_readout_packer on an 8x2 array with 4-lane beats.
module tb_pixel_readout_packer;

    localparam int PB   = 8;
    localparam int BW   = 4;
    localparam int AW   = 8;
    localparam int AH   = 2;
    localparam int FD   = 4;
    localparam int NPIX = AW * AH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode  = 1'b0;
    logic busy;
    logic ff;

    always #5 clk = ~clk;

    pixel_readout_packer_if #(.PIXEL_BITS(PB), .BUS_WIDTH(BW)) bus ();

    pixel_readout_packer #(
        .PIXEL_BITS   (PB),
        .BUS_WIDTH    (BW),
        .ARRAY_WIDTH  (AW),
        .ARRAY_HEIGHT (AH),
        .FIFO_DEPTH   (FD)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_mode           (mode),
        .bus              (bus),
        .o_busy           (busy),
        .o_frame_finished (ff)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int pix_idx = 0;
    int ff_cnt = 0;
    int ff_cyc = -1;
    int pop_last_cyc = -1;
    int start_cyc = 0;
    int feed_n = 0;
    int f0 = 0;
    logic busy_at_ff = 1'b0;
    logic [7:0]  pix [NPIX];
    logic [31:0] got_d[$];
    logic        got_nr[$];
    logic        got_last[$];
    logic [31:0] exp_d[$];
    logic        exp_nr[$];
    logic        exp_last[$];
    logic [31:0] ramp_exp [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes for the coming edge, then move to the next negedge.
    task automatic cyc();
        #1;
        if (bus.in_valid && bus.in_ready) pix_idx++;
        if (bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_data);
            got_nr.push_back(bus.out_new_row);
            got_last.push_back(bus.out_frame_last);
            if (bus.out_frame_last) pop_last_cyc = cyc_n;
        end
        if (ff) begin
            ff_cnt++;
            ff_cyc = cyc_n;
            busy_at_ff = busy;
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic start_frame(input logic m);
        start = 1'b1;
        mode = m;
        pix_idx = 0;
        start_cyc = cyc_n;
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(input int npix, input bit rnd_in, input bit rnd_out, input logic ordy,
                        input int budget);
        feed_n = 0;
        while (pix_idx < npix && feed_n < budget) begin
            bus.in_valid  = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data   = pix[pix_idx];
            bus.out_ready = rnd_out ? 1'($urandom_range(0, 1)) : ordy;
            cyc();
            feed_n++;
        end
        bus.in_valid = 1'b0;
        chk("feed_done", 64'(pix_idx), 64'(npix));
    endtask

    task automatic drain(input bit rnd_out, input int budget);
        int n;
        int c0;
        n = 0;
        c0 = ff_cnt;
        while (ff_cnt == c0 && n < budget) begin
            bus.out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            n++;
        end
        chk("drain_done", 64'(ff_cnt - c0), 64'd1);
    endtask

    task automatic clear_got();
        got_d.delete();
        got_nr.delete();
        got_last.delete();
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(i);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   64'(bus.in_ready),       64'd0);
        chk({tag, "_out_valid"},  64'(bus.out_valid),      64'd0);
        chk({tag, "_out_data"},   64'(bus.out_data),       64'd0);
        chk({tag, "_new_row"},    64'(bus.out_new_row),    64'd0);
        chk({tag, "_frame_last"}, 64'(bus.out_frame_last), 64'd0);
        chk({tag, "_busy"},       64'(busy),               64'd0);
        chk({tag, "_ff"},         64'(ff),                 64'd0);
    endtask

    // Expected beat k of the frame held in pix[], straight from the lane definitions.
    function automatic logic [31:0] model_beat(input logic m, input int k);
        logic [31:0] b;
        logic [8:0]  s;
        b = '0;
        for (int l = 0; l < BW; l++) begin
            if (!m) begin
                b[l*8 +: 8] = pix[k*BW + l];
            end else begin
                s = {1'b0, pix[k*2*BW + 2*l]} + {1'b0, pix[k*2*BW + 2*l + 1]};
                b[l*8 +: 8] = s[8:1];
            end
        end
        return b;
    endfunction

    initial begin
        logic [7:0] bin_pix [NPIX];
        logic       rmode [3];
        int         nb;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // Full-resolution ramp with a free-running output.
        load_ramp();
        clear_got();
        bus.out_ready = 1'b1;
        f0 = ff_cnt;
        start_frame(1'b0);
        chk("ramp_in_ready_after_start", 64'(bus.in_ready), 64'd1);
        chk("ramp_busy", 64'(busy), 64'd1);
        feed(NPIX, 0, 0, 1'b1, 40);
        chk("ramp_no_stall", 64'(feed_n), 64'(NPIX));
        drain(0, 20);
        chk("ramp_beats", 64'(got_d.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ramp_beat%0d", k), 64'(got_d[k]), 64'(ramp_exp[k]));
            chk($sformatf("ramp_nr%0d", k), 64'(got_nr[k]), 64'((k % 2) == 0));
            chk($sformatf("ramp_last%0d", k), 64'(got_last[k]), 64'(k == 3));
        end
        chk("ramp_ff_after_pop", 64'(ff_cyc - pop_last_cyc), 64'd1);
        chk("ramp_frame_cycles", 64'(ff_cyc - start_cyc + 1), 64'(NPIX + 3));
        chk("ramp_idle_at_ff", 64'(busy_at_ff), 64'd0);
        cyc();
        cyc();
        chk("ramp_ff_single_pulse", 64'(ff_cnt - f0), 64'd1);

        // 2:1 horizontal binning.
        bin_pix = '{8'hFF, 8'hFE, 8'h10, 8'h11, 8'h00, 8'h01, 8'h80, 8'h80,
                    8'h02, 8'h04, 8'h07, 8'h08, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        for (int i = 0; i < NPIX; i++) pix[i] = bin_pix[i];
        clear_got();
        start_frame(1'b1);
        feed(NPIX, 0, 0, 1'b1, 40);
        drain(0, 20);
        chk("bin_beats", 64'(got_d.size()), 64'd2);
        chk("bin_beat0", 64'(got_d[0]), 64'h800010FE);
        chk("bin_beat1", 64'(got_d[1]), 64'h7FFF0703);
        chk("bin_nr0", 64'(got_nr[0]), 64'd1);
        chk("bin_nr1", 64'(got_nr[1]), 64'd1);
        chk("bin_last0", 64'(got_last[0]), 64'd0);
        chk("bin_last1", 64'(got_last[1]), 64'd1);

        // Output held off for a whole frame: the FIFO absorbs exactly four beats.
        load_ramp();
        clear_got();
        bus.out_ready = 1'b0;
        start_frame(1'b0);
        feed(NPIX, 0, 0, 1'b0, 40);
        chk("bp_no_stall", 64'(feed_n), 64'(NPIX));
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_head_beat0", 64'(bus.out_data), 64'(ramp_exp[0]));
        chk("bp_head_nr", 64'(bus.out_new_row), 64'd1);
        for (int i = 0; i < 3; i++) cyc();
        chk("bp_head_stable", 64'(bus.out_data), 64'(ramp_exp[0]));
        chk("bp_no_pop", 64'(got_d.size()), 64'd0);
        drain(0, 20);
        chk("bp_beats", 64'(got_d.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_beat%0d", k), 64'(got_d[k]), 64'(ramp_exp[k]));

        // START held through the frame, MODE flipped mid-frame.
        load_ramp();
        clear_got();
        f0 = ff_cnt;
        bus.out_ready = 1'b1;
        start = 1'b1;
        mode = 1'b0;
        pix_idx = 0;
        cyc();
        chk("hold_in_ready_returns", 64'(bus.in_ready), 64'd1);
        mode = 1'b1;
        feed(NPIX, 0, 0, 1'b1, 40);
        drain(0, 20);
        chk("hold_beats", 64'(got_d.size()), 64'd4);
        chk("hold_beat0", 64'(got_d[0]), 64'(ramp_exp[0]));
        chk("hold_beat2", 64'(got_d[2]), 64'(ramp_exp[2]));
        chk("hold_one_ff", 64'(ff_cnt - f0), 64'd1);
        chk("hold_idle_at_ff", 64'(busy_at_ff), 64'd0);
        chk("hold_restart_after_ff", 64'(busy), 64'd1);

        // Reset in the middle of the restarted frame.
        start = 1'b0;
        mode = 1'b0;
        pix_idx = 0;
        feed(5, 0, 0, 1'b1, 20);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        cyc();
        cyc();
        rst_n = 1'b1;
        f0 = ff_cnt;
        for (int i = 0; i < 4; i++) cyc();
        chk("midreset_no_stale_ff", 64'(ff_cnt - f0), 64'd0);
        clear_got();
        start_frame(1'b0);
        feed(NPIX, 0, 0, 1'b1, 40);
        drain(0, 20);
        chk("midreset_beats", 64'(got_d.size()), 64'd4);
        chk("midreset_beat0", 64'(got_d[0]), 64'(ramp_exp[0]));
        chk("midreset_one_ff", 64'(ff_cnt - f0), 64'd1);

        // Three back-to-back frames with random valid/ready stalls.
        rmode = '{1'b0, 1'b1, 1'b0};
        clear_got();
        exp_d.delete();
        exp_nr.delete();
        exp_last.delete();
        f0 = ff_cnt;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
            nb = rmode[f] ? NPIX / (2 * BW) : NPIX / BW;
            for (int k = 0; k < nb; k++) begin
                exp_d.push_back(model_beat(rmode[f], k));
                exp_nr.push_back(rmode[f] ? 1'b1 : ((k % 2) == 0));
                exp_last.push_back(k == nb - 1);
            end
            start_frame(rmode[f]);
            feed(NPIX, 1, 1, 1'b0, 400);
            drain(1, 400);
        end
        chk("rand_beats", 64'(got_d.size()), 64'(exp_d.size()));
        for (int k = 0; k < exp_d.size(); k++) begin
            chk($sformatf("rand_beat%0d", k), 64'(got_d[k]), 64'(exp_d[k]));
            chk($sformatf("rand_nr%0d", k), 64'(got_nr[k]), 64'(exp_nr[k]));
            chk($sformatf("rand_last%0d", k), 64'(got_last[k]), 64'(exp_last[k]));
        end
        chk("rand_ff_count", 64'(ff_cnt - f0), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
